// File: rtl/regfile_mp_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : regfile_mp_if
// Purpose  : Read, write-back and scoreboard bundle between issue/WB and regfile_mp.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface regfile_mp_if #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2
);
   localparam int AW = $clog2(NREG);

   logic [NRD-1:0]      rs_en;
   logic [NRD*AW-1:0]   rs_index;
   logic [NRD*XLEN-1:0] rs_data;
   logic [NRD-1:0]      rs_busy;

   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_index;
   logic [NWR*XLEN-1:0] wr_data;

   logic                claim_en;
   logic [AW-1:0]       claim_index;
   logic                flush;

   modport master (
      output rs_en, rs_index, wr_en, wr_index, wr_data, claim_en, claim_index, flush,
      input  rs_data, rs_busy
   );

   modport slave (
      input  rs_en, rs_index, wr_en, wr_index, wr_data, claim_en, claim_index, flush,
      output rs_data, rs_busy
   );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : regfile_mp
// Purpose  : Multi-port register file with write-to-read bypass and busy scoreboard.
//            Optional macro REGFILE_DIFFTEST_EN adds the regs_o post-write view.
// Revision : 1.0
// ---------------------------------------------------------------------------
module regfile_mp #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int NRD  = 2,
   parameter int NWR  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef REGFILE_DIFFTEST_EN
   output logic [NREG*XLEN-1:0] regs_o,
`endif
   regfile_mp_if.slave          bus
);
   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] regs_q [1:NREG-1];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [NREG-1:0] wr_hit;
   logic [XLEN-1:0] wr_view [NREG];

   // Post-write view per register; later ports overwrite earlier ones so the
   // highest-index writer wins. Writes are suppressed while rst is high.
   always_comb begin
      wr_hit     = '0;
      wr_view[0] = '0;
      for (int i = 1; i < NREG; i++) begin
         wr_view[i] = regs_q[i];
         for (int k = 0; k < NWR; k++) begin
            if (!rst && bus.wr_en[k] && (bus.wr_index[k*AW +: AW] == AW'(i))) begin
               wr_hit[i]  = 1'b1;
               wr_view[i] = bus.wr_data[k*XLEN +: XLEN];
            end
         end
      end
   end

   // Clear on write-back, then claim, then flush: each step overrides the previous.
   always_comb begin
      busy_d = busy_q & ~wr_hit;
      if (bus.claim_en && (bus.claim_index != '0)) begin
         busy_d[bus.claim_index] = 1'b1;
      end
      if (bus.flush) begin
         busy_d = '0;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      for (int i = 1; i < NREG; i++) begin
         if (rst) begin
            regs_q[i] <= '0;
         end else if (wr_hit[i]) begin
            regs_q[i] <= wr_view[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   generate
      for (genvar j = 0; j < NRD; j++) begin : g_rd
         logic [AW-1:0] idx;
         logic          vld;

         assign idx = bus.rs_index[j*AW +: AW];
         assign vld = bus.rs_en[j] && (idx != '0);
         assign bus.rs_data[j*XLEN +: XLEN] = vld ? wr_view[idx] : '0;
         // A value arriving this cycle is bypassed, so it is not reported busy.
         assign bus.rs_busy[j] = vld & busy_q[idx] & ~wr_hit[idx];
      end
   endgenerate

`ifdef REGFILE_DIFFTEST_EN
   generate
      for (genvar i = 0; i < NREG; i++) begin : g_diff
         assign regs_o[i*XLEN +: XLEN] = wr_view[i];
      end
   endgenerate
`endif

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next core generation.
- Supports NRD read ports and NWR write-back ports, with same-cycle write-to-read bypass.
- Includes a per-register busy scoreboard: issue claims a destination, write-back releases it, flush clears all claims.
- Sits between decode/issue (reads, claims) and the write-back stage(s). x0 is hardwired to zero.

Parameters:
- XLEN, 64, register data width in bits.
- NREG, 32, number of architectural registers (power of 2, >=2). Local AW = $clog2(NREG).
- NRD, 2, number of read ports.
- NWR, 2, number of write ports. Higher port index has higher priority.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- rs_en  in  NRD  per-read-port enable
- rs_index  in  NRD*AW  read indices; port j occupies bits [j*AW +: AW]
- rs_data  out  NRD*XLEN  read data, port j at [j*XLEN +: XLEN]
- rs_busy  out  NRD  port j source has an outstanding producer
- wr_en  in  NWR  per-write-port enable
- wr_index  in  NWR*AW  write indices
- wr_data  in  NWR*XLEN  write data
- claim_en  in  1  issue claims a destination register
- claim_index  in  AW  register being claimed
- flush  in  1  clear all busy bits (pipeline flush)

Behaviour:
Storage
- Registers 1..NREG-1 are XLEN-bit flops. x0 has no storage.
- On rst at a clock edge: all registers become 0 and all busy bits become 0. wr_en, claim_en and flush are ignored in that cycle.

Writes
- At posedge, for each k with wr_en[k]=1 and wr_index[k]!=0, reg[wr_index[k]] <= wr_data[k].
- Writes to x0 are discarded.
- Two ports targeting the same index in one cycle: the highest k wins. No error is raised.

Reads
- Reads are combinational, 0-cycle latency.
- rs_en[j]=0 -> rs_data[j]=0.
- rs_index[j]==0 -> rs_data[j]=0.
- Otherwise, if any wr_en[k]=1 with wr_index[k]==rs_index[j] and rst=0, rs_data[j]=wr_data of the highest such k (bypass).
- Otherwise rs_data[j]=reg[rs_index[j]].
- While rst=1, bypass is disabled and the array value is returned.

Scoreboard (busy[NREG-1:1], busy[0] constant 0)
- Each cycle, in priority order (lowest to highest):
  - (a) Any wr_en[k] with nonzero index clears busy[wr_index[k]].
  - (b) claim_en with claim_index!=0 sets busy[claim_index]. A claim on the same index as a clear in the same cycle wins, so the register stays busy for the new producer.
  - (c) flush=1 clears every busy bit and overrides (a) and (b), including a same-cycle claim.
  - (d) rst overrides all.
- rs_busy[j] = rs_en[j] & (rs_index[j]!=0) & busy[rs_index[j]] & ~(same-cycle write to rs_index[j]).
  - A bypassed value is ready, so the port reports not busy.
  - rs_busy is combinational and does not look at same-cycle claim_en.
- Registers keep their data across flush; only the busy bits are affected.

Optional Feature:
- Macro REGFILE_DIFFTEST_EN.
- When defined: adds output regs_o (NREG*XLEN) with slot 0 = 0 and slot i = the post-write view: wr_data of the highest enabled port writing i this cycle, else reg[i]. This feeds the difftest commit checker.
- When undefined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset then read: rst 1 cycle, then rs_en=2'b11, rs_index={5,0} -> rs_data both 0, rs_busy=0.
- Dual write conflict: wr_en=2'b11, both wr_index=7, wr_data0=0x11, wr_data1=0x22 -> next cycle reading x7 returns 0x22. A write of 0xFF to x0 leaves x0 reading 0.
- Bypass: reg x3=0xA; same cycle wr_en[0]=1, x3<=0xB, rs_index[0]=3 -> rs_data[0]=0xB combinationally. rs_en=0 on the same index -> 0.
- Scoreboard: claim x9 -> next cycle rs_busy=1 for x9. Write-back x9 with a concurrent read of x9 -> rs_busy=0, data bypassed. The following cycle busy stays cleared.
- Claim vs. clear vs. flush: same cycle claim x4 and write x4 -> x4 stays busy. Repeat with flush=1 -> x4 not busy, data written.
- Reset mid-operation: busy x2, x5 set and wr_en active with rst=1 -> registers 0, all busy 0, write ignored. With REGFILE_DIFFTEST_EN, regs_o slot 2 shows a same-cycle write value when rst=0.
